// File: rtl/squeeze_seq_pkg.sv
// Shared types and constants for the squeeze layer sequencer.
package squeeze_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StAck,
    StGap,
    StDone
  } seq_state_t;

  localparam int unsigned MAX_LAYERS  = 8;
  localparam int unsigned LAYER_IDX_W = $clog2(MAX_LAYERS);

  // Expected output samples per layer; indexed by layer number.
  localparam int unsigned LAYER_SAMPLES [MAX_LAYERS] = '{
    4, 6, 3, 1024, 1024, 256, 256, 64
  };

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter with a zero flag; times the settle gap between layers.
module seq_gap_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/squeeze_layer_sequencer.sv
// Enables one layer at a time, acknowledges its finish, inserts a settle gap, moves on.
// Optional sample-count checking is built when SEQ_SAMPLE_CHECK_EN is defined.
module squeeze_layer_sequencer
  import squeeze_seq_pkg::*;
#(
  parameter int unsigned N_LAYERS   = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [N_LAYERS-1:0]         layer_en,
  input  logic [N_LAYERS-1:0]         layer_finish,
  input  logic [N_LAYERS-1:0]         layer_sample,
  output logic [N_LAYERS-1:0]         ram_feedback,
  output logic [$clog2(N_LAYERS)-1:0] cur_layer,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned IDX_W = $clog2(N_LAYERS);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [N_LAYERS-1:0] LAYER_ONE = N_LAYERS'(1);

  seq_state_t       state;
  logic             gap_zero;
  logic             is_last;
  logic             cur_finish;
  logic [IDX_W-1:0] next_layer;

  assign is_last    = (cur_layer == IDX_W'(N_LAYERS - 1));
  assign next_layer = cur_layer + IDX_W'(1);
  assign cur_finish = layer_finish[cur_layer];

  seq_gap_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == StAck),
    .load_val (GAP_W'(GAP_CYCLES - 1)),
    .en       (state == StGap),
    .zero     (gap_zero)
  );

  // All handshake outputs are registered so reset clears them without delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      layer_en     <= '0;
      ram_feedback <= '0;
      cur_layer    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ram_feedback <= '0;
      done         <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state     <= StRun;
            cur_layer <= '0;
            layer_en  <= LAYER_ONE;
            busy      <= 1'b1;
          end
        end
        StRun: begin
          if (cur_finish) begin
            state        <= StAck;
            layer_en     <= '0;
            ram_feedback <= LAYER_ONE << cur_layer;
          end
        end
        StAck: begin
          state <= StGap;
        end
        StGap: begin
          if (gap_zero) begin
            if (is_last) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= StRun;
              cur_layer <= next_layer;
              layer_en  <= LAYER_ONE << next_layer;
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifdef SEQ_SAMPLE_CHECK_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_expect;
  logic             err_q;

  // A strobe coincident with finish is included in the compared count.
  always_comb begin
    cnt_next = cnt_q;
    if (layer_sample[cur_layer] && (cnt_q != '1)) begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  assign cnt_expect = CNT_W'(LAYER_SAMPLES[LAYER_IDX_W'(cur_layer)]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if ((state == StIdle) && start) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if ((state == StGap) && gap_zero) begin
      cnt_q <= '0;
    end else if (state == StRun) begin
      cnt_q <= cnt_next;
      if (cur_finish && (cnt_next != cnt_expect)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic             unused_sample;
  logic [CNT_W-1:0] unused_cnt;

  assign unused_sample = ^layer_sample;
  assign unused_cnt    = '0;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_squeeze_layer_sequencer.sv
// Directed bench for squeeze_layer_sequencer with 3 layers, each finishing 10 cycles after enable.
module tb_squeeze_layer_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] layer_en;
  logic [2:0] layer_finish;
  logic [2:0] layer_sample;
  logic [2:0] ram_feedback;
  logic [1:0] cur_layer;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks;
  int n_fail;

  logic [3:0] lcnt [3];
  logic [2:0] fin_q;
  logic [2:0] smp_q;
  logic [2:0] fin_force;
  int         n_smp [3];

  squeeze_layer_sequencer #(
    .N_LAYERS   (3),
    .GAP_CYCLES (2),
    .CNT_W      (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .layer_en     (layer_en),
    .layer_finish (layer_finish),
    .layer_sample (layer_sample),
    .ram_feedback (ram_feedback),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer models: finish is seen by the DUT 10 edges after enable rises; n_smp strobes before it.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!layer_en[k]) begin
        lcnt[k]  <= '0;
        fin_q[k] <= 1'b0;
        smp_q[k] <= 1'b0;
      end else begin
        lcnt[k]  <= lcnt[k] + 4'd1;
        fin_q[k] <= (lcnt[k] == 4'd8);
        smp_q[k] <= (int'(lcnt[k]) < n_smp[k]);
      end
    end
  end

  assign layer_finish = fin_q | fin_force;
  assign layer_sample = smp_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Index i = edges after the edge that samples start; layer k runs edges 13k..13k+9.
  function automatic logic [2:0] exp_en(input int i);
    for (int k = 0; k < 3; k++) begin
      if (i >= 13 * k && i < 13 * k + 10) return 3'(1 << k);
    end
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_fb(input int i);
    for (int k = 0; k < 3; k++) begin
      if (i == 13 * k + 10) return 3'(1 << k);
    end
    return 3'b000;
  endfunction

  function automatic logic [1:0] exp_cur(input int i);
    if (i < 13) return 2'd0;
    if (i < 26) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic exp_err(input int i, input int n0);
`ifdef SEQ_SAMPLE_CHECK_EN
    return (n0 != 4) && (i >= 10);
`else
    return (i < 0) && (n0 < 0);
`endif
  endfunction

  // Start counts as cycle 1, so done lands on cycle 1+3*13 = 40, i.e. edge index 39.
  task automatic run_seq(input string tag, input int restart_at, input int spur_at,
                         input int n0, input int abort_at);
    n_smp[0] = n0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      check($sformatf("%s_en@%0d", tag, i), 32'(layer_en), 32'(exp_en(i)));
      check($sformatf("%s_fb@%0d", tag, i), 32'(ram_feedback), 32'(exp_fb(i)));
      check($sformatf("%s_cur@%0d", tag, i), 32'(cur_layer), 32'(exp_cur(i)));
      check($sformatf("%s_busy@%0d", tag, i), 32'(busy), 32'(i < 39));
      check($sformatf("%s_done@%0d", tag, i), 32'(done), 32'(i == 39));
      check($sformatf("%s_err@%0d", tag, i), 32'(err), 32'(exp_err(i, n0)));
      if (i == abort_at) break;
      start     = (i == restart_at);
      fin_force = (i >= spur_at && i < spur_at + 4) ? 3'b100 : 3'b000;
      @(negedge clk);
    end
    start     = 1'b0;
    fin_force = 3'b000;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    start     = 1'b0;
    fin_force = 3'b000;
    n_smp[0]  = 4;
    n_smp[1]  = 6;
    n_smp[2]  = 3;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_en", 32'(layer_en), 32'd0);
    check("rst_fb", 32'(ram_feedback), 32'd0);
    check("rst_cur", 32'(cur_layer), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_seq("basic", -1, -1, 4, -1);
    repeat (2) @(negedge clk);
    run_seq("restart", 15, -1, 4, -1);
    repeat (2) @(negedge clk);
    run_seq("spur", -1, 3, 4, -1);
    repeat (2) @(negedge clk);

    // Abort in the gap after layer 1 (edge 24); reset must clear outputs without a clock edge.
    run_seq("abort", -1, -1, 4, 24);
    rst = 1'b0;
    #1;
    check("arst_en", 32'(layer_en), 32'd0);
    check("arst_fb", 32'(ram_feedback), 32'd0);
    check("arst_cur", 32'(cur_layer), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_idle_en", 32'(layer_en), 32'd0);
    run_seq("fresh", -1, -1, 4, -1);
    repeat (2) @(negedge clk);

    // Five strobes on layer 0 against an expected four.
    run_seq("smp5", -1, -1, 5, -1);
    repeat (3) @(negedge clk);
    check("smp5_err_held", 32'(err), 32'(exp_err(40, 5)));
    run_seq("smp4", -1, -1, 4, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
